// File: rtl/logic_avalon_mm_memory_slave.sv
// rtl/logic_avalon_mm_memory_slave.sv - Avalon-MM slave memory with byte enables and pipelined read latency
module logic_avalon_mm_memory_slave #(
   parameter int DATA_BYTES    = 4,
   parameter int ADDRESS_WIDTH = 8,
   parameter int MEMORY_DEPTH  = 2**ADDRESS_WIDTH,
   parameter int READ_LATENCY  = 2
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic                     read,
   input  logic                     write,
   input  logic [8*DATA_BYTES-1:0]  writedata,
   input  logic [DATA_BYTES-1:0]    byteenable,
   output logic                     waitrequest,
   output logic [8*DATA_BYTES-1:0]  readdata,
   output logic                     readdatavalid,
   output logic [1:0]               response,
   output logic                     writeresponsevalid
);

   localparam int DW = 8 * DATA_BYTES;

   logic [DW-1:0]             mem [MEMORY_DEPTH];

   // Read pipeline: stage k holds a read accepted k edges ago; the last stage drives the outputs.
   logic [READ_LATENCY:1]     pipe_valid;
   logic [READ_LATENCY:1]     pipe_err;
   logic [DW-1:0]             pipe_data [1:READ_LATENCY];

   logic                      in_range;
   logic                      reads_in_flight;
   logic                      rd_acc;
   logic                      wr_acc;
   logic [DW-1:0]             rd_word;
   logic                      wresp_q;
   logic                      werr_q;

   assign in_range = ({1'b0, address} < (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH));

   // Reads that have not yet reached their response cycle; a write must wait for them to drain.
   always_comb begin
      reads_in_flight = 1'b0;
      for (int k = 1; k < READ_LATENCY; k++) begin
         reads_in_flight = reads_in_flight | pipe_valid[k];
      end
   end

   assign waitrequest = areset | (write & reads_in_flight);

   // read together with write is handled as a write; reads never stall outside reset
   assign wr_acc  = write & ~waitrequest;
   assign rd_acc  = read & ~write & ~areset;
   assign rd_word = in_range ? mem[address] : '0;

   // Byte-lane memory update at the edge the write is accepted; contents survive reset.
   always_ff @(posedge aclk) begin
      if (wr_acc && in_range) begin
         for (int b = 0; b < DATA_BYTES; b++) begin
            if (byteenable[b]) begin
               mem[address][8*b +: 8] <= writedata[8*b +: 8];
            end
         end
      end
   end

   // Advance the read pipeline; data only moves with a valid so readdata holds its last value.
   always_ff @(posedge aclk) begin
      if (areset) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int k = 1; k <= READ_LATENCY; k++) begin
            pipe_data[k] <= '0;
         end
      end else begin
         pipe_valid[1] <= rd_acc;
         pipe_err[1]   <= rd_acc & ~in_range;
         if (rd_acc) begin
            pipe_data[1] <= rd_word;
         end
         for (int k = 2; k <= READ_LATENCY; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
            pipe_err[k]   <= pipe_err[k-1];
            if (pipe_valid[k-1]) begin
               pipe_data[k] <= pipe_data[k-1];
            end
         end
      end
   end

   // Write response strobe one cycle after acceptance, with decode error for unimplemented words.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wresp_q <= 1'b0;
         werr_q  <= 1'b0;
      end else begin
         wresp_q <= wr_acc;
         werr_q  <= wr_acc & ~in_range;
      end
   end

   assign readdatavalid      = pipe_valid[READ_LATENCY];
   assign readdata           = pipe_data[READ_LATENCY];
   assign writeresponsevalid = wresp_q;
   assign response           = ((pipe_valid[READ_LATENCY] & pipe_err[READ_LATENCY]) |
                                (wresp_q & werr_q)) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_logic_avalon_mm_memory_slave.sv
// tb/tb_logic_avalon_mm_memory_slave.sv - self-checking bench for logic_avalon_mm_memory_slave
module tb_logic_avalon_mm_memory_slave;

   localparam int DEPTH = 200;
   localparam int LAT   = 2;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      logic [1:0]  resp;
      int          due;
   } exp_t;

   logic        aclk;
   logic        areset;
   logic [7:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;
   logic [1:0]  response;
   logic        writeresponsevalid;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] last_rd  = '0;
   logic [31:0] mdl [256];
   exp_t        q [$];

   logic_avalon_mm_memory_slave #(
      .DATA_BYTES   (4),
      .ADDRESS_WIDTH(8),
      .MEMORY_DEPTH (DEPTH),
      .READ_LATENCY (LAT)
   ) dut (
      .aclk              (aclk),
      .areset            (areset),
      .address           (address),
      .read              (read),
      .write             (write),
      .writedata         (writedata),
      .byteenable        (byteenable),
      .waitrequest       (waitrequest),
      .readdata          (readdata),
      .readdatavalid     (readdatavalid),
      .response          (response),
      .writeresponsevalid(writeresponsevalid)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      cyc <= cyc + 1;
      if (areset) last_rd <= '0;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response monitor: every strobe must match the oldest outstanding expectation at its due cycle.
   always @(negedge aclk) begin
      exp_t e;
      if (cyc > 0) begin
         check("strobe_overlap", 64'(readdatavalid & writeresponsevalid), 0);
         if (readdatavalid === 1'b1 || writeresponsevalid === 1'b1) begin
            if (q.size() == 0) begin
               check("unexpected_strobe", 64'({readdatavalid, writeresponsevalid}), 0);
            end else begin
               e = q.pop_front();
               check("resp_kind", 64'(readdatavalid), 64'(e.is_rd));
               check("resp_cycle", 64'(cyc), 64'(e.due));
               check("response", 64'(response), 64'(e.resp));
               if (e.is_rd) begin
                  check("readdata", 64'(readdata), 64'(e.data));
                  last_rd <= e.data;
               end
            end
         end else begin
            check("idle_response", 64'(response), 0);
            check("readdata_hold", 64'(readdata), 64'(last_rd));
         end
         while (q.size() > 0 && q[0].due < cyc) begin
            check("missing_response", 64'(cyc), 64'(q[0].due));
            void'(q.pop_front());
         end
      end
   end

   // Present one command, wait (bounded) for acceptance, record the expected response.
   task automatic cmd(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be, output int waits);
      exp_t e;
      read       = rd;
      write      = wr;
      address    = a;
      writedata  = d;
      byteenable = be;
      waits      = 0;
      @(negedge aclk);
      while (waitrequest === 1'b1 && waits < 16) begin
         waits++;
         @(negedge aclk);
      end
      check("accept_timeout", 64'(waitrequest), 0);
      if (wr) begin
         if (a < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
            end
         end
         e.is_rd = 1'b0;
         e.data  = '0;
         e.resp  = (a < DEPTH) ? 2'b00 : 2'b11;
         e.due   = cyc + 1;
         q.push_back(e);
      end else if (rd) begin
         e.is_rd = 1'b1;
         e.data  = (a < DEPTH) ? mdl[a] : 32'h0;
         e.resp  = (a < DEPTH) ? 2'b00 : 2'b11;
         e.due   = cyc + LAT;
         q.push_back(e);
      end
      @(posedge aclk);
      #1;
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic wait_rdv(input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
      int n = 0;
      @(negedge aclk);
      while (readdatavalid !== 1'b1 && n < 10) begin
         n++;
         @(negedge aclk);
      end
      check({tag, "_valid"}, 64'(readdatavalid), 1);
      check({tag, "_data"}, 64'(readdata), 64'(exp_data));
      check({tag, "_resp"}, 64'(response), 64'(exp_resp));
      @(posedge aclk);
      #1;
   endtask

   initial begin
      int          w;
      int          kind;
      exp_t        keep [$];
      logic [31:0] v7;

      areset = 1'b1; read = 1'b0; write = 1'b0;
      address = '0; writedata = '0; byteenable = '0;

      // reset held: stalled, silent, cleared read data
      @(posedge aclk);
      #1;
      repeat (2) begin
         @(negedge aclk);
         check("rst_waitrequest", 64'(waitrequest), 1);
         check("rst_strobes", 64'({readdatavalid, writeresponsevalid}), 0);
         check("rst_response", 64'(response), 0);
         check("rst_readdata", 64'(readdata), 0);
      end
      @(posedge aclk);
      #1;
      areset = 1'b0;
      @(negedge aclk);
      check("release_waitrequest", 64'(waitrequest), 0);
      @(posedge aclk);
      #1;

      // give every implemented word a known value
      for (int a = 0; a < DEPTH; a++) cmd(1'b0, 1'b1, 8'(a), $urandom, 4'hF, w);

      // byte-lane merge
      cmd(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'b1111, w);
      cmd(1'b0, 1'b1, 8'h10, 32'h000000AA, 4'b0001, w);
      cmd(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, w);
      wait_rdv(32'hDEADBEAA, 2'b00, "merge");

      // back-to-back reads never stall
      for (int a = 1; a <= 3; a++) begin
         cmd(1'b1, 1'b0, 8'(a), 32'h0, 4'h0, w);
         check("burst_stall", 64'(w), 0);
      end
      idle(4);

      // write behind a read waits READ_LATENCY-1 cycles
      cmd(1'b1, 1'b0, 8'h05, 32'h0, 4'h0, w);
      cmd(1'b0, 1'b1, 8'h06, $urandom, 4'hF, w);
      check("write_stall", 64'(w), LAT - 1);
      idle(3);

      // unimplemented word: decode error, zero data, memory untouched
      cmd(1'b0, 1'b1, 8'hF0, 32'h12345678, 4'hF, w);
      cmd(1'b1, 1'b0, 8'hF0, 32'h0, 4'h0, w);
      wait_rdv(32'h0, 2'b11, "oor_read");
      cmd(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, w);
      wait_rdv(32'hDEADBEAA, 2'b00, "inrange_after_oor");

      // reset drops an in-flight read and blocks a simultaneous write
      v7 = $urandom;
      cmd(1'b0, 1'b1, 8'h07, v7, 4'hF, w);
      idle(2);
      cmd(1'b1, 1'b0, 8'h07, 32'h0, 4'h0, w);
      areset = 1'b1; write = 1'b1; address = 8'h07; writedata = ~v7; byteenable = 4'hF;
      keep.delete();
      foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
      q = keep;
      @(negedge aclk);
      check("rst_pulse_waitrequest", 64'(waitrequest), 1);
      @(posedge aclk);
      #1;
      areset = 1'b0; write = 1'b0;
      idle(4);
      cmd(1'b1, 1'b0, 8'h07, 32'h0, 4'h0, w);
      wait_rdv(v7, 2'b00, "read_after_reset");

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 2);
         cmd(kind == 0 || kind == 2, kind != 0, 8'($urandom_range(0, 255)),
             $urandom, 4'($urandom), w);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      idle(6);
      check("queue_drained", 64'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
